// File: rtl/attn_pkg.sv
// Shared constants and types for the attention result writeback path.
package attn_pkg;

    localparam int DIN_W  = 256;
    localparam int LINE_W = 512;
    localparam int ADDR_W = 12;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_t;

    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_FULL = 2'b11;

endpackage

// File: rtl/attn_out_packer_if.sv
// Half-line input stream and line write port of the result packer.
interface attn_out_packer_if;
    import attn_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DIN_W-1:0]  in_data;
    logic              in_last;
    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W-2:0] m_addr;
    logic [LINE_W-1:0] m_data;
    logic [1:0]        m_be;

    modport slave (
        input  in_valid, in_addr, in_data, in_last, m_ready,
        output in_ready, m_valid, m_addr, m_data, m_be
    );

    modport master (
        output in_valid, in_addr, in_data, in_last, m_ready,
        input  in_ready, m_valid, m_addr, m_data, m_be
    );

endinterface

// File: rtl/attn_line_fifo.sv
// Synchronous line FIFO; head entry reads as zero while empty so outputs are clean after reset.
module attn_line_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/attn_out_packer.sv
// Pairs even/odd 256-bit result halves into 512-bit lines and writes them out through a line FIFO.
module attn_out_packer
    import attn_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TOTAL_LINES = 2048
) (
    input  logic               clk,
    input  logic               rst_n,
    attn_out_packer_if.slave   bus,
    output logic               seq_err,
    output logic               done,
    output logic [31:0]        busy_cycles
);

    localparam int LA_W  = ADDR_W - 1;
    localparam int FW    = LA_W + LINE_W + 2;
    localparam int CNT_W = $clog2(TOTAL_LINES + 1);

    pack_state_t       state;
    logic [DIN_W-1:0]  hold_data;
    logic [ADDR_W-1:0] hold_addr;
    logic              rdy_en;
    logic              started;
    logic [CNT_W-1:0]  line_cnt;

    logic              accept;
    logic              odd;
    logic              pair;
    logic              load_hold;
    logic              push;
    logic [LA_W-1:0]   push_addr;
    logic [LINE_W-1:0] push_line;
    logic [1:0]        push_be;
    logic              err_evt;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FW-1:0]     head;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // in_ready depends only on registered state; rdy_en keeps it low while in reset
    assign bus.in_ready = rdy_en & ~fifo_full & ~done;
    assign accept       = bus.in_valid & bus.in_ready;
    assign odd          = bus.in_addr[0];
    assign pair         = (bus.in_addr == hold_addr + ADDR_W'(1));
    assign load_hold    = accept & ~odd & ((state == HALF) | ~bus.in_last);

    always_comb begin
        push      = 1'b0;
        push_addr = bus.in_addr[ADDR_W-1:1];
        push_line = {{DIN_W{1'b0}}, bus.in_data};
        push_be   = BE_LO;
        err_evt   = 1'b0;
        if (accept) begin
            case (state)
                EMPTY: begin
                    if (odd)              err_evt = 1'b1;
                    else if (bus.in_last) push    = 1'b1;
                end
                HALF: begin
                    push      = 1'b1;
                    push_addr = hold_addr[ADDR_W-1:1];
                    if (pair) begin
                        push_line = {bus.in_data, hold_data};
                        push_be   = BE_FULL;
                    end else begin
                        push_line = {{DIN_W{1'b0}}, hold_data};
                        err_evt   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else if (accept) begin
            case (state)
                EMPTY:   if (!odd && !bus.in_last) state <= HALF;
                HALF:    if (odd) state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (load_hold) begin
            hold_data <= bus.in_data;
            hold_addr <= bus.in_addr;
        end
    end

    attn_line_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({push_addr, push_line, push_be}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign pop         = bus.m_valid & bus.m_ready;
    assign bus.m_valid = ~fifo_empty;
    assign bus.m_addr  = head[FW-1 -: LA_W];
    assign bus.m_data  = head[LINE_W+1:2];
    assign bus.m_be    = head[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en      <= 1'b0;
            started     <= 1'b0;
            seq_err     <= 1'b0;
            line_cnt    <= '0;
            done        <= 1'b0;
            busy_cycles <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (accept)  started <= 1'b1;
            if (err_evt) seq_err <= 1'b1;
            if (pop && !done) begin
                line_cnt <= line_cnt + CNT_W'(1);
                if (line_cnt == CNT_W'(TOTAL_LINES - 1)) done <= 1'b1;
            end
            if ((started || accept) && !done) busy_cycles <= sat_inc(busy_cycles);
        end
    end

endmodule
